// File: rtl/kv_cmd_pkg.sv
// Shared definitions for the key/value command decoder: opcode encoding,
// opcode ASCII characters and the default line terminator.
package kv_cmd_pkg;

  typedef enum logic [1:0] {
    OP_SET   = 2'd0,
    OP_GET   = 2'd1,
    OP_REFER = 2'd2,
    OP_DEL   = 2'd3
  } kv_op_e;

  localparam logic [7:0] KV_CHAR_SET     = 8'h53; // 'S'
  localparam logic [7:0] KV_CHAR_GET     = 8'h47; // 'G'
  localparam logic [7:0] KV_CHAR_REFER   = 8'h52; // 'R'
  localparam logic [7:0] KV_CHAR_DEL     = 8'h44; // 'D'
  localparam logic [7:0] KV_TERM_DEFAULT = 8'h0A;

endpackage

// File: rtl/kv_op_lookup.sv
// Combinational opcode-character decode; upper-case only, anything else invalid.
module kv_op_lookup
  import kv_cmd_pkg::*;
(
  input  logic [7:0] i_byte,
  output kv_op_e     o_op,
  output logic       o_valid
);

  always_comb begin
    o_op    = OP_SET;
    o_valid = 1'b1;
    case (i_byte)
      KV_CHAR_SET:   o_op = OP_SET;
      KV_CHAR_GET:   o_op = OP_GET;
      KV_CHAR_REFER: o_op = OP_REFER;
      KV_CHAR_DEL:   o_op = OP_DEL;
      default:       o_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/cmd_decoder.sv
// Byte-stream command line decoder with held output and stall detection.
// Optional error counter output enabled by macro CMD_DECODER_ERRCNT_EN.
module cmd_decoder
  import kv_cmd_pkg::*;
#(
  parameter logic [7:0]  TERM_CHAR = KV_TERM_DEFAULT,
  parameter int unsigned STALL_MAX = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  logic [7:0] in_byte,
  output logic       in_ready,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output logic [1:0] cmd_op,
  output logic [7:0] cmd_key,
  output logic [7:0] cmd_val,
  output logic       err_pulse
`ifdef CMD_DECODER_ERRCNT_EN
  ,
  output logic [7:0] err_count
`endif
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_KEY     = 3'd1;
  localparam logic [2:0] ST_VAL     = 3'd2;
  localparam logic [2:0] ST_TERM    = 3'd3;
  localparam logic [2:0] ST_EMIT    = 3'd4;
  localparam logic [2:0] ST_DISCARD = 3'd5;

  localparam int unsigned SW = (STALL_MAX < 2) ? 1 : $clog2(STALL_MAX + 1);
  localparam logic [SW-1:0] STALL_LIM    = SW'(STALL_MAX);
  localparam logic [SW-1:0] STALL_LIM_M1 = SW'(STALL_MAX - 1);

  logic [2:0]    r_state;
  kv_op_e        r_op;
  logic [7:0]    r_key;
  logic [7:0]    r_val;
  logic          r_err;
  logic [SW-1:0] r_stall;

  kv_op_e w_op;
  logic   w_op_ok;
  logic   w_xfer;
  logic   w_is_term;

  kv_op_lookup u_lookup (
    .i_byte  (in_byte),
    .o_op    (w_op),
    .o_valid (w_op_ok)
  );

  assign in_ready  = (r_state != ST_EMIT);
  assign w_xfer    = in_valid && in_ready;
  assign w_is_term = (in_byte == TERM_CHAR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_op    <= OP_SET;
      r_key   <= '0;
      r_val   <= '0;
      r_err   <= 1'b0;
      r_stall <= '0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        ST_IDLE: if (w_xfer) begin
          if (w_op_ok) begin
            r_op    <= w_op;
            r_val   <= '0;
            r_state <= ST_KEY;
          end else if (!w_is_term) begin
            r_state <= ST_DISCARD;
            r_err   <= 1'b1;
          end
        end
        // Key and value bytes are raw data, even when equal to the terminator.
        ST_KEY: if (w_xfer) begin
          r_key   <= in_byte;
          r_state <= (r_op == OP_SET) ? ST_VAL : ST_TERM;
        end
        ST_VAL: if (w_xfer) begin
          r_val   <= in_byte;
          r_state <= ST_TERM;
        end
        ST_TERM: if (w_xfer) begin
          if (w_is_term) begin
            r_state <= ST_EMIT;
          end else begin
            r_state <= ST_DISCARD;
            r_err   <= 1'b1;
          end
        end
        ST_DISCARD: if (w_xfer && w_is_term) r_state <= ST_IDLE;
        ST_EMIT: begin
          if (cmd_ready) begin
            r_state <= ST_IDLE;
            r_stall <= '0;
          end else if (r_stall != STALL_LIM) begin
            r_stall <= r_stall + 1'b1;
            if (r_stall == STALL_LIM_M1) r_err <= 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign cmd_valid = (r_state == ST_EMIT);
  assign cmd_op    = r_op;
  assign cmd_key   = r_key;
  assign cmd_val   = r_val;
  assign err_pulse = r_err;

`ifdef CMD_DECODER_ERRCNT_EN
  logic [7:0] r_err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                         r_err_cnt <= '0;
    else if (r_err && r_err_cnt != '1)  r_err_cnt <= r_err_cnt + 1'b1;
  end

  assign err_count = r_err_cnt;
`endif

endmodule

// File: tb/tb_cmd_decoder.sv
// Directed table-driven bench for cmd_decoder plus stall and reset sequences.
module tb_cmd_decoder;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic [7:0] in_byte;
  logic       in_ready;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [7:0] cmd_key;
  logic [7:0] cmd_val;
  logic       err_pulse;
`ifdef CMD_DECODER_ERRCNT_EN
  logic [7:0] err_count;
`endif

  cmd_decoder #(.TERM_CHAR(8'h0A), .STALL_MAX(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_byte   (in_byte),
    .in_ready  (in_ready),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_key   (cmd_key),
    .cmd_val   (cmd_val),
    .err_pulse (err_pulse)
`ifdef CMD_DECODER_ERRCNT_EN
    ,
    .err_count (err_count)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Cumulative monitor of DUT outputs, sampled on the falling edge.
  int         mon_valid = 0;
  int         mon_err   = 0;
  logic [1:0] mon_op;
  logic [7:0] mon_key;
  logic [7:0] mon_val;

  always @(negedge clk) begin
    if (cmd_valid) begin
      mon_valid = mon_valid + 1;
      mon_op    = cmd_op;
      mon_key   = cmd_key;
      mon_val   = cmd_val;
    end
    if (err_pulse) mon_err = mon_err + 1;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    int guard;
    @(negedge clk);
    in_valid = 1'b1;
    in_byte  = b;
    guard    = 0;
    while (!in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) check("send_timeout", 32'd1, 32'd0);
    @(posedge clk);
  endtask

  task automatic idle(input int n);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  typedef struct {
    logic [7:0] b0, b1, b2, b3;
    int         n;
    int         cmds;
    logic [1:0] op;
    logic [7:0] key;
    logic [7:0] val;
    int         errs;
  } vec_t;

  vec_t vecs[9];

  function automatic vec_t mk(input logic [7:0] b0, b1, b2, b3, input int n, cmds,
                              input logic [1:0] op, input logic [7:0] key, val,
                              input int errs);
    vec_t v;
    v.b0 = b0; v.b1 = b1; v.b2 = b2; v.b3 = b3;
    v.n = n; v.cmds = cmds; v.op = op; v.key = key; v.val = val; v.errs = errs;
    return v;
  endfunction

  initial begin
    int v0, e0, err_idx, nerr_stall;
    logic [7:0] bytes [4];
    logic held_ok;

    vecs[0] = mk(8'h53, 8'h05, 8'h2A, 8'h0A, 4, 1, 2'd0, 8'h05, 8'h2A, 0);
    vecs[1] = mk(8'h52, 8'h0A, 8'h0A, 8'h00, 3, 1, 2'd2, 8'h0A, 8'h00, 0);
    vecs[2] = mk(8'h58, 8'h31, 8'h0A, 8'h00, 3, 0, 2'd0, 8'h00, 8'h00, 1);
    vecs[3] = mk(8'h47, 8'h03, 8'h0A, 8'h00, 3, 1, 2'd1, 8'h03, 8'h00, 0);
    vecs[4] = mk(8'h44, 8'h07, 8'h0A, 8'h00, 3, 1, 2'd3, 8'h07, 8'h00, 0);
    vecs[5] = mk(8'h0A, 8'h00, 8'h00, 8'h00, 1, 0, 2'd0, 8'h00, 8'h00, 0);
    vecs[6] = mk(8'h73, 8'h01, 8'h0A, 8'h00, 3, 0, 2'd0, 8'h00, 8'h00, 1);
    vecs[7] = mk(8'h47, 8'h01, 8'h02, 8'h0A, 4, 0, 2'd0, 8'h00, 8'h00, 1);
    vecs[8] = mk(8'h53, 8'h0A, 8'h0A, 8'h0A, 4, 1, 2'd0, 8'h0A, 8'h0A, 0);

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_byte   = 8'h00;
    cmd_ready = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
    check("rst_err_pulse", {31'd0, err_pulse}, 32'd0);
    check("rst_cmd_key", {24'd0, cmd_key}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Latency: cmd_valid one cycle after the terminator edge, for exactly one cycle.
    send(8'h53); send(8'h11); send(8'h22); send(8'h0A);
    @(negedge clk);
    in_valid = 1'b0;
    check("lat_cmd_valid_rise", {31'd0, cmd_valid}, 32'd1);
    check("lat_in_ready_low", {31'd0, in_ready}, 32'd0);
    @(negedge clk);
    check("lat_cmd_valid_fall", {31'd0, cmd_valid}, 32'd0);
    idle(2);

    foreach (vecs[i]) begin
      v0 = mon_valid;
      e0 = mon_err;
      bytes[0] = vecs[i].b0; bytes[1] = vecs[i].b1;
      bytes[2] = vecs[i].b2; bytes[3] = vecs[i].b3;
      for (int j = 0; j < vecs[i].n; j++) send(bytes[j]);
      idle(4);
      check($sformatf("v%0d_cmds", i), mon_valid - v0, vecs[i].cmds);
      check($sformatf("v%0d_errs", i), mon_err - e0, vecs[i].errs);
      if (vecs[i].cmds > 0) begin
        check($sformatf("v%0d_op", i), {30'd0, mon_op}, {30'd0, vecs[i].op});
        check($sformatf("v%0d_key", i), {24'd0, mon_key}, {24'd0, vecs[i].key});
        check($sformatf("v%0d_val", i), {24'd0, mon_val}, {24'd0, vecs[i].val});
      end
    end

    // Stall: command held 300 cycles, one overrun pulse 255 cycles after cmd_valid rises.
    cmd_ready = 1'b0;
    send(8'h44); send(8'h07); send(8'h0A);
    err_idx    = -1;
    nerr_stall = 0;
    held_ok    = 1'b1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (!cmd_valid || in_ready || cmd_op != 2'd3 || cmd_key != 8'h07) held_ok = 1'b0;
      if (err_pulse) begin
        nerr_stall++;
        err_idx = i;
      end
    end
    check("stall_held", {31'd0, held_ok}, 32'd1);
    check("stall_err_count", nerr_stall, 32'd1);
    check("stall_err_cycle", err_idx, 32'd255);
    v0 = mon_valid;
    cmd_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", {31'd0, cmd_valid}, 32'd0);
    check("stall_release_ready", {31'd0, in_ready}, 32'd1);
    idle(2);
`ifdef CMD_DECODER_ERRCNT_EN
    check("err_count_total", {24'd0, err_count}, 32'd4);
`endif

    // Reset mid-frame discards the partial command silently.
    send(8'h53); send(8'h01);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_key", {24'd0, cmd_key}, 32'd0);
    check("midrst_valid", {31'd0, cmd_valid}, 32'd0);
    check("midrst_op", {30'd0, cmd_op}, 32'd0);
`ifdef CMD_DECODER_ERRCNT_EN
    check("midrst_err_count", {24'd0, err_count}, 32'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    v0 = mon_valid;
    e0 = mon_err;
    send(8'h47); send(8'h09); send(8'h0A);
    idle(4);
    check("postrst_cmds", mon_valid - v0, 32'd1);
    check("postrst_errs", mon_err - e0, 32'd0);
    check("postrst_op", {30'd0, mon_op}, 32'd1);
    check("postrst_key", {24'd0, mon_key}, 32'h09);
    check("postrst_val", {24'd0, mon_val}, 32'h00);

    // Reset while a command is pending in EMIT drops it.
    cmd_ready = 1'b0;
    send(8'h47); send(8'h05); send(8'h0A);
    @(negedge clk);
    in_valid = 1'b0;
    check("emitrst_pending", {31'd0, cmd_valid}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("emitrst_valid", {31'd0, cmd_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    cmd_ready = 1'b1;
    v0 = mon_valid;
    e0 = mon_err;
    repeat (4) @(negedge clk);
    check("emitrst_no_cmd", mon_valid - v0, 32'd0);
    check("emitrst_no_err", mon_err - e0, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
